// File: rtl/tracking_pkg.sv
// ----------------------------------------------------------------------------
// tracking_pkg
// Shared definitions for target_tracking_unit and its range_timer sub-module:
//   - ttu_state_e : FSM state encoding (IDLE=00, SCAN=01, LOCKED=10, FIRING=11)
//   - DEF_*       : default values for the top-level parameters
//   - CNT_W       : width of the saturating hit/miss counters
//   - sat_inc     : saturating increment used by those counters
// ----------------------------------------------------------------------------
package tracking_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SCAN   = 2'b01,
        LOCKED = 2'b10,
        FIRING = 2'b11
    } ttu_state_e;

    localparam int DEF_MAX_RANGE_CYC = 64;
    localparam int DEF_DIST_W        = 8;
    localparam int DEF_LOCK_HITS     = 3;
    localparam int DEF_MISS_LIMIT    = 2;
    localparam int DEF_ACK_TIMEOUT   = 8;

    localparam int CNT_W  = 4;
    localparam int AMMO_W = 4;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/target_tracking_unit_if.sv
// ----------------------------------------------------------------------------
// target_tracking_unit_if
// Fire-control handshake between the tracking unit and the weapons control
// unit (WCU).
//   fire_command       : tracker -> WCU, fire request held until ack/timeout
//   launch_missile     : WCU -> tracker, acknowledge
//   remaining_missiles : WCU -> tracker, ammo count
// Modports: master = tracking unit side, slave = weapons control unit side.
// ----------------------------------------------------------------------------
interface target_tracking_unit_if;
    import tracking_pkg::*;

    logic              fire_command;
    logic              launch_missile;
    logic [AMMO_W-1:0] remaining_missiles;

    modport master (
        output fire_command,
        input  launch_missile,
        input  remaining_missiles
    );

    modport slave (
        input  fire_command,
        output launch_missile,
        output remaining_missiles
    );

endinterface

// File: rtl/target_tracking_unit_range_timer.sv
// ----------------------------------------------------------------------------
// range_timer
// Radar ranging engine. While enabled it emits a one-cycle pulse_radar, counts
// cycles since that pulse and reports the outcome of each window as a one-cycle
// strobe in the result cycle:
//   hit  : rising echo edge at delay k, 1 <= k < MAX_RANGE_CYC (echo_delay = k)
//   miss : delay reached MAX_RANGE_CYC with no echo edge
// The next window's pulse follows the cycle after every hit/miss.
// Ports: clk, rst (sync, active-high), enable, radar_echo ->
//        pulse_radar, hit, miss, echo_delay[DIST_W].
// ----------------------------------------------------------------------------
module range_timer #(
    parameter int MAX_RANGE_CYC = 64,
    parameter int DIST_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              radar_echo,
    output logic              pulse_radar,
    output logic              hit,
    output logic              miss,
    output logic [DIST_W-1:0] echo_delay
);

    localparam logic [DIST_W-1:0] MAX_K = DIST_W'(MAX_RANGE_CYC);

    logic [DIST_W-1:0] cnt_q, cnt_d;
    logic              echo_prev_q;
    logic              echo_rise;

    assign echo_rise   = radar_echo & ~echo_prev_q;
    // cnt_q == 0 is the pulse cycle; an echo edge there is not a valid return.
    assign pulse_radar = enable && (cnt_q == '0);
    assign hit         = enable && echo_rise && (cnt_q != '0) && (cnt_q < MAX_K);
    assign miss        = enable && (cnt_q >= MAX_K);
    assign echo_delay  = cnt_q;

    // Disabled timer parks at 0 so the first enabled cycle is a pulse cycle.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!enable || hit || miss) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            echo_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            echo_prev_q <= radar_echo;
        end
    end

endmodule

// File: rtl/target_tracking_unit.sv
// ----------------------------------------------------------------------------
// target_tracking_unit
// Radar tracking and fire-control initiator. Runs ranging windows through
// range_timer, locks after LOCK_HITS consecutive hits, drops lock after
// MISS_LIMIT consecutive misses, and turns operator fire requests into a
// fire_command handshake closed by launch_missile or an ACK_TIMEOUT timeout.
// Ports:
//   clk, rst (sync, active-high)
//   scan_for_target, radar_echo, operator_fire : control inputs
//   wcu (target_tracking_unit_if.master)       : fire_command / launch_missile /
//                                                remaining_missiles
//   pulse_radar, distance_to_target[DIST_W], target_locked, fire_fault,
//   TTU_state[2]                               : status outputs
// Build option: define TTU_RANGE_AVG_EN to report each hit distance as the
// average of k and the previous hit distance; undefined reports raw k.
// ----------------------------------------------------------------------------
module target_tracking_unit
    import tracking_pkg::*;
#(
    parameter int MAX_RANGE_CYC = DEF_MAX_RANGE_CYC,
    parameter int DIST_W        = DEF_DIST_W,
    parameter int LOCK_HITS     = DEF_LOCK_HITS,
    parameter int MISS_LIMIT    = DEF_MISS_LIMIT,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_for_target,
    input  logic                  radar_echo,
    input  logic                  operator_fire,
    target_tracking_unit_if.master wcu,
    output logic                  pulse_radar,
    output logic [DIST_W-1:0]     distance_to_target,
    output logic                  target_locked,
    output logic                  fire_fault,
    output logic [1:0]            TTU_state
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    ttu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              fault_q, fault_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic [DIST_W-1:0] new_dist;

    logic              hit, miss;
    logic [DIST_W-1:0] echo_delay;

    range_timer #(
        .MAX_RANGE_CYC (MAX_RANGE_CYC),
        .DIST_W        (DIST_W)
    ) u_range_timer (
        .clk         (clk),
        .rst         (rst),
        .enable      (state_q != IDLE),
        .radar_echo  (radar_echo),
        .pulse_radar (pulse_radar),
        .hit         (hit),
        .miss        (miss),
        .echo_delay  (echo_delay)
    );

`ifdef TTU_RANGE_AVG_EN
    // avg_valid_q marks that dist_q holds a hit from the current scan session.
    logic              avg_valid_q, avg_valid_d;
    logic [DIST_W:0]   avg_sum;

    assign avg_sum  = {1'b0, echo_delay} + {1'b0, dist_q};
    assign new_dist = avg_valid_q ? avg_sum[DIST_W:1] : echo_delay;

    always_comb begin
        avg_valid_d = avg_valid_q;
        if (!scan_for_target) begin
            avg_valid_d = 1'b0;
        end else if (hit) begin
            avg_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= avg_valid_d;
        end
    end
`else
    assign new_dist = echo_delay;
`endif

    always_comb begin
        dist_d = dist_q;
        if (scan_for_target && hit) begin
            dist_d = new_dist;
        end
    end

    // Counters are updated first so lock / lock-loss act on this cycle's result.
    always_comb begin
        state_d    = state_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        tmo_d      = tmo_q;
        fault_d    = fault_q;
        if (!scan_for_target) begin
            state_d    = IDLE;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            tmo_d      = '0;
        end else begin
            if (hit) begin
                hit_cnt_d  = sat_inc(hit_cnt_q);
                miss_cnt_d = '0;
            end else if (miss) begin
                miss_cnt_d = sat_inc(miss_cnt_q);
                hit_cnt_d  = '0;
            end
            case (state_q)
                IDLE: state_d = SCAN;
                SCAN: begin
                    if (hit_cnt_d >= CNT_W'(LOCK_HITS)) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (miss_cnt_d >= CNT_W'(MISS_LIMIT)) begin
                        state_d = SCAN;
                    end else if (operator_fire && (wcu.remaining_missiles != '0)) begin
                        state_d = FIRING;
                        tmo_d   = '0;
                        fault_d = 1'b0;
                    end
                end
                FIRING: begin
                    // Lock loss outranks the acknowledge, which outranks timeout.
                    if (miss_cnt_d >= CNT_W'(MISS_LIMIT)) begin
                        state_d = SCAN;
                        tmo_d   = '0;
                    end else if (wcu.launch_missile) begin
                        state_d = LOCKED;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                        state_d = LOCKED;
                        tmo_d   = '0;
                        fault_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            tmo_q      <= '0;
            fault_q    <= 1'b0;
            dist_q     <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            tmo_q      <= tmo_d;
            fault_q    <= fault_d;
            dist_q     <= dist_d;
        end
    end

    assign distance_to_target = dist_q;
    assign target_locked      = (state_q == LOCKED) || (state_q == FIRING);
    assign wcu.fire_command   = (state_q == FIRING);
    assign fire_fault         = fault_q;
    assign TTU_state          = state_q;

endmodule

// File: tb/tb_target_tracking_unit.sv
module tb_target_tracking_unit;

    localparam int MAXR = 64;
    localparam int LH   = 3;
    localparam int ML   = 2;
    localparam int AT   = 8;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       scan = 1'b0;
    logic       echo = 1'b0;
    logic       opf  = 1'b0;
    logic       pulse;
    logic [7:0] distance;
    logic       locked;
    logic       fault;
    logic [1:0] state;

    target_tracking_unit_if wif();

    target_tracking_unit dut (
        .clk                (clk),
        .rst                (rst),
        .scan_for_target    (scan),
        .radar_echo         (echo),
        .operator_fire      (opf),
        .wcu                (wif),
        .pulse_radar        (pulse),
        .distance_to_target (distance),
        .target_locked      (locked),
        .fire_fault         (fault),
        .TTU_state          (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 0;
    int echo_k   = 0;

    // ---------------- behavioural model (timestamp based) ----------------
    int m_st, m_win, m_hits, m_miss, m_dist, m_fault, m_fire_start;
    bit m_prev, m_avg;

    always @(posedge clk) begin : model
        int c, k;
        bit rise, hit, miss;
        c = cyc;
        if (rst) begin
            m_st = 0; m_win = 0; m_hits = 0; m_miss = 0; m_dist = 0;
            m_fault = 0; m_fire_start = 0; m_prev = 0; m_avg = 0;
            chk_en = 1;
        end else begin
            k    = c - m_win;
            rise = echo && !m_prev;
            hit  = (m_st != 0) && rise && (k >= 1) && (k < MAXR);
            miss = (m_st != 0) && (k >= MAXR);
            if (!scan) begin
                m_st = 0; m_hits = 0; m_miss = 0; m_avg = 0;
            end else begin
                if (hit) begin
                    m_hits = (m_hits < 15) ? m_hits + 1 : 15;
                    m_miss = 0;
`ifdef TTU_RANGE_AVG_EN
                    m_dist = m_avg ? (k + m_dist) / 2 : k;
`else
                    m_dist = k;
`endif
                    m_avg = 1;
                    m_win = c + 1;
                end else if (miss) begin
                    m_miss = (m_miss < 15) ? m_miss + 1 : 15;
                    m_hits = 0;
                    m_win  = c + 1;
                end
                case (m_st)
                    0: begin m_st = 1; m_win = c + 1; end
                    1: if (m_hits >= LH) m_st = 2;
                    2: begin
                        if (m_miss >= ML) m_st = 1;
                        else if (opf && wif.remaining_missiles != 0) begin
                            m_st = 3; m_fire_start = c + 1; m_fault = 0;
                        end
                    end
                    default: begin
                        if (m_miss >= ML) m_st = 1;
                        else if (wif.launch_missile) m_st = 2;
                        else if (c - m_fire_start + 1 >= AT) begin
                            m_st = 2; m_fault = 1;
                        end
                    end
                endcase
            end
            m_prev = echo;
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin : compare
        logic [13:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = {((m_st != 0) && (cyc == m_win)), 8'(m_dist), (m_st >= 2),
                     (m_st == 3), m_fault[0], 2'(m_st)};
            act_v = {pulse, distance, locked, wif.fire_command, fault, state};
            checks = checks + 1;
            if (act_v !== exp_v) begin
                failures = failures + 1;
                $display("FAIL model_cycle cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
            end
        end
    end

    // ---------------- echo generator: one-cycle echo k cycles after pulse ----------------
    initial begin
        @(negedge clk);
        forever begin
            if (pulse && echo_k > 0) begin
                repeat (echo_k) @(negedge clk);
                echo = 1'b1;
                @(negedge clk);
                echo = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic lit(input string name, input int act, input int exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    function automatic int outs();
        return int'({pulse, distance, locked, wif.fire_command, fault, state});
    endfunction

    int t_pulse, hi, d_exp;

    initial begin
        wif.launch_missile     = 1'b0;
        wif.remaining_missiles = 4'd4;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        lit("reset_outputs", outs(), 0);
        rst = 1'b0; scan = 1'b1; echo_k = 10;

        // acquisition: k=10 in three windows
        for (int i = 0; i < 10 && !pulse; i++) @(negedge clk);
        lit("first_pulse", pulse, 1);
        t_pulse = cyc;
        for (int i = 0; i < 40 && distance == 0; i++) @(negedge clk);
        lit("dist_first_window", distance, 10);
        lit("dist_latency", cyc - t_pulse, 11);
        lit("state_scan", state, 1);
        for (int i = 0; i < 100 && !locked; i++) @(negedge clk);
        lit("lock_latency", cyc - t_pulse, 33);
        lit("locked_state", state, 2);
        lit("locked_flag", locked, 1);

        // fire with acknowledge at n+3
        opf = 1'b1; @(negedge clk); opf = 1'b0;
        lit("fire_n1", wif.fire_command, 1);
        @(negedge clk); lit("fire_n2", wif.fire_command, 1);
        @(negedge clk); lit("fire_n3", wif.fire_command, 1);
        wif.launch_missile = 1'b1;
        @(negedge clk); wif.launch_missile = 1'b0;
        lit("fire_n4_low", wif.fire_command, 0);
        lit("state_after_ack", state, 2);

        // no ammo: request ignored
        wif.remaining_missiles = 4'd0; opf = 1'b1;
        repeat (3) begin
            @(negedge clk);
            lit("noammo_fire", wif.fire_command, 0);
            lit("noammo_state", state, 2);
        end
        opf = 1'b0; wif.remaining_missiles = 4'd4;
        @(negedge clk);

        // timeout: high exactly 8 cycles, fault rises as it falls
        opf = 1'b1; @(negedge clk); opf = 1'b0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (wif.fire_command) hi++;
            if (i == 7) lit("tmo_last_high_nofault", fault, 0);
            if (i == 8) begin
                lit("tmo_fire_low", wif.fire_command, 0);
                lit("tmo_fault", fault, 1);
                lit("tmo_state", state, 2);
            end
            @(negedge clk);
        end
        lit("tmo_high_cycles", hi, 8);
        opf = 1'b1; @(negedge clk); opf = 1'b0;
        lit("refire_cmd", wif.fire_command, 1);
        lit("refire_fault_clr", fault, 0);
        wif.launch_missile = 1'b1; @(negedge clk); wif.launch_missile = 1'b0;
        lit("refire_ack_low", wif.fire_command, 0);

        // distance with k=20 after k=10 hits
        echo_k = 20;
        for (int i = 0; i < 100 && distance == 10; i++) @(negedge clk);
`ifdef TTU_RANGE_AVG_EN
        lit("dist_k20", distance, 15);
        d_exp = 17;
`else
        lit("dist_k20", distance, 20);
        d_exp = 20;
`endif
        repeat (3) @(negedge clk);
        echo_k = 0;

        // two missed windows drop lock
        for (int i = 0; i < 300 && locked; i++) @(negedge clk);
        lit("lost_locked", locked, 0);
        lit("lost_state", state, 1);
        lit("dist_holds", distance, d_exp);

        // reset during FIRING
        echo_k = 10;
        for (int i = 0; i < 200 && !locked; i++) @(negedge clk);
        lit("relock", locked, 1);
        opf = 1'b1; @(negedge clk); opf = 1'b0;
        @(negedge clk);
        lit("prerst_firing", state, 3);
        rst = 1'b1; @(negedge clk);
        lit("rst_midfire_outputs", outs(), 0);
        rst = 1'b0;

        // scan_for_target low forces IDLE
        repeat (5) @(negedge clk);
        lit("scan_again", state, 1);
        scan = 1'b0; @(negedge clk);
        lit("scan_low_idle", state, 0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
